// File: rtl/bin_window_scanner_pkg.sv
// Shared types and elaboration-time helpers for the binary window filters.
package bin_filter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FIN
    } scan_state_t;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = int'(i) + 1;
        end
        return result;
    endfunction

    function automatic int num_windows(input int img, input int win, input int step);
        return (img - win) / step + 1;
    endfunction

    function automatic int default_thresh(input int win);
        return (win * win) / 2;
    endfunction

endpackage

// File: rtl/bin_window_scanner_if.sv
// Frame-memory read channel: address request handshake plus in-order pixel return.
interface bin_window_scanner_if #(
    parameter int ADDR_W = 8
);
    logic              addr_valid;
    logic              addr_ready;
    logic [ADDR_W-1:0] x_addr;
    logic [ADDR_W-1:0] y_addr;
    logic              pix_valid;
    logic              pix_in;

    modport master (
        output addr_valid, x_addr, y_addr,
        input  addr_ready, pix_valid, pix_in
    );

    modport slave (
        input  addr_valid, x_addr, y_addr,
        output addr_ready, pix_valid, pix_in
    );
endinterface

// File: rtl/bin_window_acc.sv
// Return path: counts pixels per window, sums ones, thresholds, tracks result coordinates.
module bin_window_acc
    import bin_filter_pkg::*;
#(
    parameter int WIN_SIZE = 3,
    parameter int WIN_STEP = 1,
    parameter int ADDR_W   = 8,
    parameter int THRESH   = 4,
    parameter int CNT_W    = 16,
    parameter int LAST_WX  = 237
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   pixTake,
    input  logic                   pixBit,
    output logic                   win_valid,
    output logic                   win_out,
    output logic [ADDR_W-1:0]      win_x,
    output logic [ADDR_W-1:0]      win_y,
`ifdef WIN_SUM_OUT_EN
    output logic [clog2(WIN_SIZE*WIN_SIZE+1)-1:0] win_sum,
`endif
    output logic [CNT_W-1:0]       active_count
);
    localparam int SUM_W    = clog2(WIN_SIZE * WIN_SIZE + 1);
    localparam int LAST_PIX = WIN_SIZE * WIN_SIZE - 1;

    logic [SUM_W-1:0]  pixCnt;
    logic [SUM_W-1:0]  ones;
    logic [SUM_W-1:0]  sumNow;
    logic              hit;
    logic [ADDR_W-1:0] rxWx;
    logic [ADDR_W-1:0] rxWy;

    // The closing pixel of a window is folded into the sum in the same cycle.
    assign sumNow = ones + SUM_W'(pixBit);
    assign hit    = int'(sumNow) > THRESH;

    always_ff @(posedge clk) begin
        if (reset) begin
            pixCnt       <= '0;
            ones         <= '0;
            rxWx         <= '0;
            rxWy         <= '0;
            win_valid    <= 1'b0;
            win_out      <= 1'b0;
            win_x        <= '0;
            win_y        <= '0;
            active_count <= '0;
`ifdef WIN_SUM_OUT_EN
            win_sum      <= '0;
`endif
        end else begin
            win_valid <= 1'b0;
            if (clear) begin
                pixCnt       <= '0;
                ones         <= '0;
                rxWx         <= '0;
                rxWy         <= '0;
                active_count <= '0;
            end else if (pixTake) begin
                if (pixCnt == SUM_W'(LAST_PIX)) begin
                    pixCnt    <= '0;
                    ones      <= '0;
                    win_valid <= 1'b1;
                    win_out   <= hit;
                    win_x     <= rxWx;
                    win_y     <= rxWy;
`ifdef WIN_SUM_OUT_EN
                    win_sum   <= sumNow;
`endif
                    if (hit) active_count <= active_count + CNT_W'(1);
                    if (rxWx == ADDR_W'(LAST_WX)) begin
                        rxWx <= '0;
                        rxWy <= rxWy + ADDR_W'(WIN_STEP);
                    end else begin
                        rxWx <= rxWx + ADDR_W'(WIN_STEP);
                    end
                end else begin
                    pixCnt <= pixCnt + SUM_W'(1);
                    ones   <= sumNow;
                end
            end
        end
    end

endmodule

// File: rtl/bin_window_scanner.sv
// Scans every WIN_SIZE x WIN_SIZE window of a binary frame and reports its majority bit.
// Optional macro WIN_SUM_OUT_EN adds the win_sum ones-count output.
module bin_window_scanner
    import bin_filter_pkg::*;
#(
    parameter int WIN_SIZE = 3,
    parameter int WIN_STEP = 1,
    parameter int IMG_W    = 240,
    parameter int IMG_H    = 180,
    parameter int ADDR_W   = 8,
    parameter int THRESH   = default_thresh(WIN_SIZE),
    parameter int CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    bin_window_scanner_if.master   mem,
    output logic                   win_valid,
    output logic                   win_out,
    output logic [ADDR_W-1:0]      win_x,
    output logic [ADDR_W-1:0]      win_y,
    output logic [CNT_W-1:0]       active_count,
`ifdef WIN_SUM_OUT_EN
    output logic [clog2(WIN_SIZE*WIN_SIZE+1)-1:0] win_sum,
`endif
    output logic                   done
);
    localparam int NUM_WX    = num_windows(IMG_W, WIN_SIZE, WIN_STEP);
    localparam int NUM_WY    = num_windows(IMG_H, WIN_SIZE, WIN_STEP);
    localparam int LAST_WX   = (NUM_WX - 1) * WIN_STEP;
    localparam int LAST_WY   = (NUM_WY - 1) * WIN_STEP;
    localparam int TOTAL_PIX = NUM_WX * NUM_WY * WIN_SIZE * WIN_SIZE;
    localparam int OUT_W     = clog2(TOTAL_PIX + 1);

    scan_state_t       state;
    logic [ADDR_W-1:0] col, row, wx, wy;
    logic [ADDR_W-1:0] nCol, nRow, nWx, nWy;
    logic              lastCol, lastRow, lastWx, lastWy, lastAddr;
    logic              accept, take;
    logic [OUT_W-1:0]  pending;

    assign accept = mem.addr_valid && mem.addr_ready;
    assign take   = mem.pix_valid && (state == ISSUE || state == DRAIN);

    always_comb begin
        lastCol = col == ADDR_W'(WIN_SIZE - 1);
        lastRow = row == ADDR_W'(WIN_SIZE - 1);
        lastWx  = wx == ADDR_W'(LAST_WX);
        lastWy  = wy == ADDR_W'(LAST_WY);
        nCol    = col + ADDR_W'(1);
        nRow    = row;
        nWx     = wx;
        nWy     = wy;
        if (lastCol) begin
            nCol = '0;
            if (lastRow) begin
                nRow = '0;
                if (lastWx) begin
                    nWx = '0;
                    nWy = wy + ADDR_W'(WIN_STEP);
                end else begin
                    nWx = wx + ADDR_W'(WIN_STEP);
                end
            end else begin
                nRow = row + ADDR_W'(1);
            end
        end
        lastAddr = lastCol && lastRow && lastWx && lastWy;
    end

    // Issued-minus-received pixels; DRAIN ends once every accepted read has returned.
    always_ff @(posedge clk) begin
        if (reset || state == IDLE) begin
            pending <= '0;
        end else begin
            pending <= pending + OUT_W'(accept) - OUT_W'(take);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            mem.addr_valid <= 1'b0;
            mem.x_addr     <= '0;
            mem.y_addr     <= '0;
            col            <= '0;
            row            <= '0;
            wx             <= '0;
            wy             <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state          <= ISSUE;
                        busy           <= 1'b1;
                        mem.addr_valid <= 1'b1;
                        mem.x_addr     <= '0;
                        mem.y_addr     <= '0;
                        col            <= '0;
                        row            <= '0;
                        wx             <= '0;
                        wy             <= '0;
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        col        <= nCol;
                        row        <= nRow;
                        wx         <= nWx;
                        wy         <= nWy;
                        mem.x_addr <= nWx + nCol;
                        mem.y_addr <= nWy + nRow;
                        if (lastAddr) begin
                            state          <= DRAIN;
                            mem.addr_valid <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (pending == '0) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    bin_window_acc #(
        .WIN_SIZE (WIN_SIZE),
        .WIN_STEP (WIN_STEP),
        .ADDR_W   (ADDR_W),
        .THRESH   (THRESH),
        .CNT_W    (CNT_W),
        .LAST_WX  (LAST_WX)
    ) u_acc (
        .clk          (clk),
        .reset        (reset),
        .clear        (state == IDLE && start),
        .pixTake      (take),
        .pixBit       (mem.pix_in),
        .win_valid    (win_valid),
        .win_out      (win_out),
        .win_x        (win_x),
        .win_y        (win_y),
`ifdef WIN_SUM_OUT_EN
        .win_sum      (win_sum),
`endif
        .active_count (active_count)
    );

endmodule

// File: tb/tb_bin_window_scanner.sv
// Directed bench: 3x3 windows over a 6x5 frame (stride 1) and a 9x9 frame (stride 3).
module tb_bin_window_scanner;
    import bin_filter_pkg::*;

    localparam int AW = 8;
    localparam int SW = clog2(10);

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset = 1'b1;

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // DUT A: 6x5 frame, stride 1 -> 4x3 windows
    logic startA = 1'b0, busyA, winValidA, winOutA, doneA;
    logic [AW-1:0] winXA, winYA;
    logic [15:0] activeA;
    bin_window_scanner_if #(.ADDR_W(AW)) memA ();
`ifdef WIN_SUM_OUT_EN
    logic [SW-1:0] sumA;
`endif
    bin_window_scanner #(.WIN_SIZE(3), .WIN_STEP(1), .IMG_W(6), .IMG_H(5),
                         .ADDR_W(AW), .THRESH(4), .CNT_W(16)) dutA (
        .clk(clk), .reset(reset), .start(startA), .busy(busyA), .mem(memA),
        .win_valid(winValidA), .win_out(winOutA), .win_x(winXA), .win_y(winYA),
        .active_count(activeA),
`ifdef WIN_SUM_OUT_EN
        .win_sum(sumA),
`endif
        .done(doneA));

    // DUT B: 9x9 frame, stride 3 -> 3x3 non-overlapping windows
    logic startB = 1'b0, busyB, winValidB, winOutB, doneB;
    logic [AW-1:0] winXB, winYB;
    logic [15:0] activeB;
    bin_window_scanner_if #(.ADDR_W(AW)) memB ();
`ifdef WIN_SUM_OUT_EN
    logic [SW-1:0] sumB;
`endif
    bin_window_scanner #(.WIN_SIZE(3), .WIN_STEP(3), .IMG_W(9), .IMG_H(9),
                         .ADDR_W(AW), .THRESH(4), .CNT_W(16)) dutB (
        .clk(clk), .reset(reset), .start(startB), .busy(busyB), .mem(memB),
        .win_valid(winValidB), .win_out(winOutB), .win_x(winXB), .win_y(winYB),
        .active_count(activeB),
`ifdef WIN_SUM_OUT_EN
        .win_sum(sumB),
`endif
        .done(doneB));

    logic imgA [0:4][0:5];

    function automatic int onesA(input int wx, input int wy);
        int s;
        s = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                s += int'(imgA[wy + r][wx + c]);
        return s;
    endfunction

    function automatic int modelActiveA();
        int n;
        n = 0;
        for (int j = 0; j < 12; j++) if (onesA(j % 4, j / 4) > 4) n++;
        return n;
    endfunction

    typedef struct { logic v; int due; } ret_t;
    ret_t qA[$];
    int cycA = 0, lastDueA = 0, latMaxA = 0;
    bit stallEnA = 1'b0, stalledA = 1'b0;
    int acceptCntA = 0, winCntA = 0, doneCntA = 0;
    logic [AW-1:0] prevXA, prevYA;

    // Memory A: optional ready stalls and 1..8 cycle in-order latency; also monitors results.
    initial begin
        memA.addr_ready = 1'b0;
        memA.pix_valid  = 1'b0;
        memA.pix_in     = 1'b0;
        forever begin
            @(negedge clk);
            cycA++;
            if (stalledA && !reset) begin
                check("holdX", memA.x_addr, prevXA);
                check("holdY", memA.y_addr, prevYA);
            end
            if (qA.size() > 0 && qA[0].due <= cycA) begin
                memA.pix_valid = 1'b1;
                memA.pix_in    = qA[0].v;
                void'(qA.pop_front());
            end else begin
                memA.pix_valid = 1'b0;
                memA.pix_in    = 1'b0;
            end
            memA.addr_ready = stallEnA ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (memA.addr_valid && memA.addr_ready) begin
                int w, p, due;
                ret_t r;
                w = acceptCntA / 9;
                p = acceptCntA % 9;
                check("addrX", memA.x_addr, w % 4 + p % 3);
                check("addrY", memA.y_addr, w / 4 + p / 3);
                due = cycA + 1 + int'($urandom_range(0, latMaxA));
                if (due < lastDueA) due = lastDueA;
                lastDueA = due;
                r.v   = (memA.x_addr < 6 && memA.y_addr < 5) ? imgA[memA.y_addr][memA.x_addr] : 1'b0;
                r.due = due;
                qA.push_back(r);
                acceptCntA++;
            end
            stalledA = memA.addr_valid && !memA.addr_ready;
            prevXA   = memA.x_addr;
            prevYA   = memA.y_addr;
            if (winValidA) begin
                int ones;
                ones = (winCntA < 12) ? onesA(winCntA % 4, winCntA / 4) : 0;
                check("winIndexA", winCntA < 12, 1);
                check("winXA", winXA, winCntA % 4);
                check("winYA", winYA, winCntA / 4);
                check("winOutA", winOutA, ones > 4);
`ifdef WIN_SUM_OUT_EN
                check("winSumA", sumA, ones);
`endif
                winCntA++;
            end
            if (doneA) doneCntA++;
        end
    end

    logic pendB = 1'b0, pendBitB = 1'b0;
    int winCntB = 0, doneCntB = 0;

    // Memory B: always ready, fixed 1-cycle latency; checkerboard of 3x3 blocks.
    initial begin
        memB.addr_ready = 1'b1;
        memB.pix_valid  = 1'b0;
        memB.pix_in     = 1'b0;
        forever begin
            @(negedge clk);
            memB.pix_valid = pendB;
            memB.pix_in    = pendBitB;
            pendB    = memB.addr_valid;
            pendBitB = ((int'(memB.x_addr) / 3 + int'(memB.y_addr) / 3) % 2) == 1;
            if (winValidB) begin
                check("winXB", winXB, (winCntB % 3) * 3);
                check("winYB", winYB, (winCntB / 3) * 3);
                check("winOutB", winOutB, ((winCntB % 3) + (winCntB / 3)) % 2);
`ifdef WIN_SUM_OUT_EN
                check("winSumB", sumB, (((winCntB % 3) + (winCntB / 3)) % 2) * 9);
`endif
                winCntB++;
            end
            if (doneB) doneCntB++;
        end
    end

    task automatic checkResetA(input string tag);
        check({tag, "_busy"}, busyA, 0);
        check({tag, "_addrValid"}, memA.addr_valid, 0);
        check({tag, "_xAddr"}, memA.x_addr, 0);
        check({tag, "_yAddr"}, memA.y_addr, 0);
        check({tag, "_winValid"}, winValidA, 0);
        check({tag, "_winOut"}, winOutA, 0);
        check({tag, "_winX"}, winXA, 0);
        check({tag, "_winY"}, winYA, 0);
        check({tag, "_active"}, activeA, 0);
        check({tag, "_done"}, doneA, 0);
    endtask

    task automatic fillA(input int mode);
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 6; x++)
                imgA[y][x] = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic runFrameA(input string tag, input int expActive, input bit midStart, input bit b2b);
        acceptCntA = 0;
        winCntA    = 0;
        doneCntA   = 0;
        @(negedge clk) startA = 1'b1;
        @(negedge clk) startA = 1'b0;
        check({tag, "_busy"}, busyA, 1);
        for (int i = 0; i < 4000 && !doneA; i++) begin
            @(posedge clk); #1;
            startA = midStart && (i == 10);
        end
        check({tag, "_doneSeen"}, doneA, 1);
        // A start coinciding with done must not begin a new frame.
        startA = b2b;
        @(posedge clk); #1;
        startA = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_windows"}, winCntA, 12);
        check({tag, "_accepts"}, acceptCntA, 108);
        check({tag, "_active"}, activeA, expActive);
        check({tag, "_donePulses"}, doneCntA, 1);
        check({tag, "_idleBusy"}, busyA, 0);
        check({tag, "_idleValid"}, memA.addr_valid, 0);
    endtask

    initial begin
        fillA(0);
        repeat (3) @(posedge clk);
        #1;
        checkResetA("rst");
        check("rstB_busy", busyB, 0);
        check("rstB_active", activeB, 0);
        check("rstB_done", doneB, 0);
        reset = 1'b0;

        fillA(1);
        runFrameA("ones", 12, 1'b0, 1'b0);

        // Window (0,0) holds exactly THRESH ones, then THRESH+1.
        fillA(0);
        imgA[0][0] = 1'b1; imgA[0][1] = 1'b1; imgA[0][2] = 1'b1; imgA[1][0] = 1'b1;
        runFrameA("four", 0, 1'b0, 1'b0);
        imgA[1][1] = 1'b1;
        runFrameA("five", 1, 1'b0, 1'b0);

        fillA(2);
        stallEnA = 1'b1;
        latMaxA  = 7;
        runFrameA("rand", modelActiveA(), 1'b1, 1'b1);

        // Abort mid-ISSUE, then rerun a frame with a known single active window.
        fillA(1);
        acceptCntA = 0;
        winCntA    = 0;
        @(negedge clk) startA = 1'b1;
        @(negedge clk) startA = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("abort_inIssue", memA.addr_valid, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        checkResetA("abort");
        qA.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        fillA(0);
        imgA[0][0] = 1'b1; imgA[0][1] = 1'b1; imgA[0][2] = 1'b1; imgA[1][0] = 1'b1; imgA[1][1] = 1'b1;
        runFrameA("afterAbort", 1, 1'b0, 1'b0);
        stallEnA = 1'b0;
        latMaxA  = 0;

        winCntB  = 0;
        doneCntB = 0;
        @(negedge clk) startB = 1'b1;
        @(negedge clk) startB = 1'b0;
        check("strideB_busy", busyB, 1);
        for (int i = 0; i < 2000 && !doneB; i++) begin
            @(posedge clk); #1;
        end
        check("strideB_doneSeen", doneB, 1);
        repeat (4) @(posedge clk);
        #1;
        check("strideB_windows", winCntB, 9);
        check("strideB_active", activeB, 4);
        check("strideB_donePulses", doneCntB, 1);
        check("strideB_idleBusy", busyB, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
